recon_block_reader: RTL and testbench

RECON_BLOCK_READER -- requirements
Module: recon_block_reader

---
 rtl/intra_pkg.sv | 17 +
 rtl/recon_addr_gen.sv | 51 +++++
 rtl/recon_block_reader.sv | 128 ++++++++++++
 tb/tb_recon_block_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/intra_pkg.sv
// Shared types and constants for the intra/reconstruction read path.
package intra_pkg;

  typedef logic [7:0] pixel_t;

  localparam int unsigned BLK4         = 4;
  localparam int unsigned FRAME_WIDTH  = 1280;
  localparam int unsigned FRAME_HEIGHT = 720;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } reader_state_t;

endpackage

// File: rtl/recon_addr_gen.sv
// Raster position of the current 4x4 block, last-block detection and
// pixel address generation (row*WIDTH + col, unsigned, 20 bits).
module recon_addr_gen
  import intra_pkg::*;
#(
  parameter int unsigned WIDTH  = FRAME_WIDTH,
  parameter int unsigned HEIGHT = FRAME_HEIGHT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        advance,
  input  logic [3:0]  idx,
  output logic [15:0] row,
  output logic [15:0] col,
  output logic        last,
  output logic [19:0] addr
);

  logic        col_wrap;
  logic [19:0] pix_row;
  logic [19:0] pix_col;

  assign col_wrap = (col == 16'(WIDTH - BLK4));
  assign last     = col_wrap && (row == 16'(HEIGHT - BLK4));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_wrap) begin
        col <= '0;
        row <= row + 16'(BLK4);
      end else begin
        col <= col + 16'(BLK4);
      end
    end
  end

  // idx walks the block row-major: idx[3:2] is the row offset, idx[1:0] the column offset.
  always_comb begin
    pix_row = 20'(row) + 20'(idx[3:2]);
    pix_col = 20'(col) + 20'(idx[1:0]);
    addr    = pix_row * 20'(WIDTH) + pix_col;
  end

endmodule

// File: rtl/recon_block_reader.sv
// Reads a reconstructed frame as raster-ordered 4x4 blocks with valid/ready output.
// Optional frame checksum output enabled by RECON_READER_CHECKSUM_EN.
module recon_block_reader
  import intra_pkg::*;
#(
  parameter int unsigned WIDTH  = FRAME_WIDTH,
  parameter int unsigned HEIGHT = FRAME_HEIGHT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         mem_rd_en,
  output logic [19:0]  mem_addr,
  input  pixel_t       mem_rdata,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [127:0] blk_data,
  output logic [15:0]  blk_row,
  output logic [15:0]  blk_col,
  output logic         done
`ifdef RECON_READER_CHECKSUM_EN
  ,
  output logic [31:0]  frame_sum
`endif
);

  reader_state_t state, state_d;
  logic [4:0]    issue_cnt;
  logic [3:0]    rd_idx;
  logic [3:0]    cap_idx;
  logic          cap_pend;
  logic          start_acc;
  logic          handshake;
  logic          last_cap;
  logic          last_blk;
  logic [19:0]   addr;

  recon_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_acc),
    .advance (handshake && !last_blk),
    .idx     (issue_cnt[3:0]),
    .row     (blk_row),
    .col     (blk_col),
    .last    (last_blk),
    .addr    (addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    start_acc = 1'b0;
    handshake = 1'b0;
    last_cap  = (state == FETCH) && cap_pend && (cap_idx == 4'd15);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (last_cap) state_d = PRESENT;
      end
      PRESENT: begin
        if (blk_ready) begin
          handshake = 1'b1;
          state_d   = last_blk ? DONE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads are registered, memory answers one cycle later, so each pixel is
  // captured two edges after its issue; cap_pend/cap_idx carry that delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      blk_valid <= 1'b0;
      blk_data  <= '0;
      done      <= 1'b0;
      issue_cnt <= '0;
      rd_idx    <= '0;
      cap_idx   <= '0;
      cap_pend  <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      cap_pend  <= mem_rd_en;
      cap_idx   <= rd_idx;
      if (start_acc) begin
        issue_cnt <= '0;
        done      <= 1'b0;
      end
      if (state == FETCH && issue_cnt < 5'd16) begin
        mem_rd_en <= 1'b1;
        mem_addr  <= addr;
        rd_idx    <= issue_cnt[3:0];
        issue_cnt <= issue_cnt + 5'd1;
      end
      if (state == FETCH && cap_pend) blk_data[{cap_idx, 3'b000} +: 8] <= mem_rdata;
      if (last_cap) blk_valid <= 1'b1;
      if (handshake) begin
        blk_valid <= 1'b0;
        issue_cnt <= '0;
        if (last_blk) done <= 1'b1;
      end
    end
  end

`ifdef RECON_READER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       frame_sum <= '0;
    else if (start_acc)              frame_sum <= '0;
    else if (state == FETCH && cap_pend) frame_sum <= frame_sum + 32'(mem_rdata);
  end
`endif

endmodule

// File: tb/tb_recon_block_reader.sv
// Self-checking bench for recon_block_reader on an 8x8 frame with a behavioural memory model.
module tb_recon_block_reader;

  localparam int unsigned W = 8;
  localparam int unsigned H = 8;
  localparam int unsigned NBLK = (W / 4) * (H / 4);

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         mem_rd_en;
  logic [19:0]  mem_addr;
  logic [7:0]   mem_rdata;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic [15:0]  blk_row;
  logic [15:0]  blk_col;
  logic         done;
`ifdef RECON_READER_CHECKSUM_EN
  logic [31:0]  frame_sum;
`endif

  logic [7:0] mem [W*H];
  int vectors     = 0;
  int miscompares = 0;
  int oob         = 0;

  recon_block_reader #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_row   (blk_row),
    .blk_col   (blk_col),
    .done      (done)
`ifdef RECON_READER_CHECKSUM_EN
    ,
    .frame_sum (frame_sum)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data for a strobe appears one cycle later; junk otherwise.
  always @(posedge clk) begin
    if (mem_rd_en && mem_addr >= 20'(W * H)) oob++;
    mem_rdata <= mem_rd_en ? mem[mem_addr[5:0]] : 8'h5A;
  end

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic int blk_r(input int b);
    return (b / int'(W / 4)) * 4;
  endfunction

  function automatic int blk_c(input int b);
    return (b % int'(W / 4)) * 4;
  endfunction

  function automatic logic [127:0] exp_block(input int b);
    logic [127:0] r;
    r = '0;
    for (int n = 0; n < 16; n++)
      r[8*n +: 8] = mem[(blk_r(b) + n / 4) * int'(W) + blk_c(b) + n % 4];
    return r;
  endfunction

  function automatic logic [319:0] exp_addrs(input int b);
    logic [319:0] r;
    r = '0;
    for (int n = 0; n < 16; n++)
      r[20*n +: 20] = 20'((blk_r(b) + n / 4) * int'(W) + blk_c(b) + n % 4);
    return r;
  endfunction

  function automatic logic [182:0] all_outs();
    return {mem_rd_en, mem_addr, blk_valid, blk_data, blk_row, blk_col, done};
  endfunction

  // Entered just after the edge that sampled start or the previous handshake.
  task automatic run_block(input int b);
    logic [31:0]  rd_hist;
    logic [319:0] addrs;
    int na;
    int lat;
    rd_hist = '0;
    addrs   = '0;
    na      = 0;
    lat     = 0;
    for (int t = 1; t <= 40 && !blk_valid; t++) begin
      tick();
      lat = t;
      if (mem_rd_en) begin
        rd_hist[t] = 1'b1;
        if (na < 16) addrs[20*na +: 20] = mem_addr;
        na++;
      end
    end
    chk($sformatf("latency_b%0d", b), 320'(lat), 320'd18);
    chk($sformatf("rd_en_window_b%0d", b), 320'(rd_hist), 320'h1_FFFE);
    chk($sformatf("addr_seq_b%0d", b), addrs, exp_addrs(b));
    chk($sformatf("blk_data_b%0d", b), 320'(blk_data), 320'(exp_block(b)));
    chk($sformatf("blk_row_b%0d", b), 320'(blk_row), 320'(blk_r(b)));
    chk($sformatf("blk_col_b%0d", b), 320'(blk_col), 320'(blk_c(b)));
    chk($sformatf("done_low_b%0d", b), 320'(done), 320'd0);
  endtask

  task automatic run_frame(input string tag);
    blk_ready = 1'b1;
    for (int b = 0; b < int'(NBLK); b++) begin
      run_block(b);
      tick();
    end
    chk({tag, "_done"}, 320'(done), 320'd1);
    chk({tag, "_valid_after_last"}, 320'(blk_valid), 320'd0);
  endtask

  initial begin
    int stable;
    int quiet;
    reset     = 1'b1;
    start     = 1'b0;
    blk_ready = 1'b0;
    for (int a = 0; a < int'(W * H); a++) mem[a] = 8'(a);
    tick();
    tick();
    chk("reset_state", 320'(all_outs()), 320'd0);
    reset = 1'b0;
    tick();

    // Frame with memory[a]=a and ready held high.
    pulse_start();
    run_frame("frameA");
    repeat (5) tick();
    chk("done_held", 320'({done, mem_rd_en, blk_valid}), 320'b100);

    // Random frame: start in DONE, backpressure on block 0, start pulsed while presenting.
    for (int a = 0; a < int'(W * H); a++) mem[a] = 8'($urandom);
    blk_ready = 1'b0;
    pulse_start();
    chk("done_cleared", 320'(done), 320'd0);
    run_block(0);
    stable = 0;
    for (int k = 0; k < 10; k++) begin
      start = (k == 3);
      tick();
      if (blk_valid && blk_data === exp_block(0) && blk_row == 16'd0 &&
          blk_col == 16'd0 && !mem_rd_en) stable++;
    end
    start = 1'b0;
    chk("backpressure_hold", 320'(stable), 320'd10);
    blk_ready = 1'b1;
    tick();
    for (int b = 1; b < int'(NBLK); b++) begin
      run_block(b);
      tick();
    end
    chk("frameB_done", 320'(done), 320'd1);

    // Reset during the fifth FETCH cycle aborts the frame.
    for (int a = 0; a < int'(W * H); a++) mem[a] = 8'($urandom);
    pulse_start();
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("reset_mid_fetch", 320'(all_outs()), 320'd0);
    tick();
    reset = 1'b0;
    quiet = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (blk_valid || mem_rd_en) quiet++;
    end
    chk("no_activity_after_abort", 320'(quiet), 320'd0);
    pulse_start();
    run_frame("frameC");

`ifdef RECON_READER_CHECKSUM_EN
    begin
      logic [31:0] sum;
      sum = '0;
      for (int a = 0; a < int'(W * H); a++) begin
        mem[a] = 8'hFF;
        sum += 32'(mem[a]);
      end
      pulse_start();
      chk("frame_sum_cleared", 320'(frame_sum), 320'd0);
      run_frame("frameD");
      chk("frame_sum", 320'(frame_sum), 320'(sum));
    end
`endif

    chk("oob_reads", 320'(oob), 320'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
